// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned FLG_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h3;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h4;
  localparam logic [OPC_W-1:0] OP_SHL = 4'h5;
  localparam logic [OPC_W-1:0] OP_SHR = 4'h6;
  localparam logic [OPC_W-1:0] OP_NOT = 4'h7;
  localparam logic [OPC_W-1:0] OP_LTU = 4'h8;
  localparam logic [OPC_W-1:0] OP_GTU = 4'h9;
  localparam logic [OPC_W-1:0] OP_MUL = 4'hA;
  localparam logic [OPC_W-1:0] OP_SRA = 4'hB;

  // Bit positions inside the {N,V,C,Z} flag vector
  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 2;
  localparam int unsigned FLG_N = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product.
// o_done rises after the last step and stays high until the next start.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_hi_nz
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_done  = r_done;
  assign o_lo    = r_acc[WIDTH-1:0];
  assign o_hi_nz = |r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU between operand fetch and writeback: valid/ready on both sides,
// {N,V,C,Z} flags, single-cycle ops at full rate and an optional iterative MUL.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [FLG_W-1:0] out_flags,
  output logic             out_err
);

  localparam int unsigned MSB = WIDTH - 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TAG_W-1:0] r_mul_tag;

  logic             w_out_free;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_load_single;
  logic             w_load_mul;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_big_shift;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic [FLG_W-1:0] w_flg;

  logic             w_mul_done;
  logic             w_mul_hi_nz;
  logic [WIDTH-1:0] w_mul_lo;
  logic [FLG_W-1:0] w_mul_flg;

  // Handshake: the output slot is free when empty or being drained this edge
  assign w_out_free    = ~out_valid | out_ready;
  assign in_ready      = (r_state == ST_IDLE) & w_out_free;
  assign w_accept      = in_valid & in_ready;
  assign w_is_mul      = MUL_EN && (in_opcode == OP_MUL);
  assign w_mul_start   = w_accept & w_is_mul;
  assign w_load_single = w_accept & ~w_is_mul;
  assign w_load_mul    = (r_state == ST_BUSY) & w_mul_done & w_out_free;

  // Extra top bit carries out (ADD) or borrow (SUB)
  assign w_sum       = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff      = {1'b0, in_a} - {1'b0, in_b};
  assign w_big_shift = (in_b >= WIDTH'(WIDTH));

  // Single-cycle datapath and flags
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    w_flg = '0;
    case (in_opcode)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (in_a[MSB] == in_b[MSB]) & (w_sum[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (in_a[MSB] != in_b[MSB]) & (w_diff[MSB] != in_a[MSB]);
      end
      OP_AND: w_res = in_a & in_b;
      OP_OR:  w_res = in_a | in_b;
      OP_XOR: w_res = in_a ^ in_b;
      OP_SHL: w_res = w_big_shift ? '0 : (in_a << in_b);
      OP_SHR: w_res = w_big_shift ? '0 : (in_a >> in_b);
      OP_NOT: w_res = ~in_a;
      OP_LTU: w_res = WIDTH'(in_a < in_b);
      OP_GTU: w_res = WIDTH'(in_a > in_b);
      OP_SRA: w_res = w_big_shift ? {WIDTH{in_a[MSB]}} : WIDTH'($signed(in_a) >>> in_b);
      default: w_err = 1'b1;
    endcase
    if (!w_err) begin
      w_flg[FLG_Z] = (w_res == '0);
      w_flg[FLG_C] = w_c;
      w_flg[FLG_V] = w_v;
      w_flg[FLG_N] = w_res[MSB];
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_start),
        .i_a     (in_a),
        .i_b     (in_b),
        .o_done  (w_mul_done),
        .o_lo    (w_mul_lo),
        .o_hi_nz (w_mul_hi_nz)
      );
    end else begin : g_no_mul
      assign w_mul_done  = 1'b0;
      assign w_mul_lo    = '0;
      assign w_mul_hi_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    w_mul_flg        = '0;
    w_mul_flg[FLG_Z] = (w_mul_lo == '0);
    w_mul_flg[FLG_C] = w_mul_hi_nz;
    w_mul_flg[FLG_N] = w_mul_lo[MSB];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_load_mul)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_tag <= '0;
    end else if (w_mul_start) begin
      r_mul_tag <= in_tag;
    end
  end

  // Output register: load wins over drain so a result can stream in as the old one leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
      out_err    <= 1'b0;
    end else if (w_load_mul) begin
      out_valid  <= 1'b1;
      out_result <= w_mul_lo;
      out_tag    <= r_mul_tag;
      out_flags  <= w_mul_flg;
      out_err    <= 1'b0;
    end else if (w_load_single) begin
      out_valid  <= 1'b1;
      out_result <= w_res;
      out_tag    <= in_tag;
      out_flags  <= w_flg;
      out_err    <= w_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops push expected results, a monitor pops on each output transfer.
module tb_alu_pipe;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4;
  localparam logic [3:0] SHL = 4'h5, SHR = 4'h6, NOT_ = 4'h7, LTU = 4'h8, GTU = 4'h9;
  localparam logic [3:0] MUL = 4'hA, SRA = 4'hB, ILL = 4'hF;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  tag;
    logic [3:0]  flg;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;
  logic        out_err;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .TAG_W(4), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .out_err    (out_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare {result,tag,flags,err} on every output transfer
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {15'd0, out_result, out_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_rtfe", 32'({out_result, out_tag, out_flags, out_err}),
            32'({mon_e.res, mon_e.tag, mon_e.flg, mon_e.err}));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input logic [15:0] res, input logic [3:0] flg,
                      input logic err);
    int waited = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back('{res, tag, flg, err});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stray;
    int waited;
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_tag",    32'(out_tag),    32'd0);
    chk("rst_out_flags",  32'(out_flags),  32'd0);
    chk("rst_out_err",    32'(out_err),    32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Add/sub flags; flags are {N,V,C,Z}
    send(ADD, 16'hFFFF, 16'h0001, 4'h3, 16'h0000, 4'b0011, 1'b0);
    chk("add_one_cycle_latency", 32'(out_valid), 32'd1);
    send(SUB, 16'h8000, 16'h0001, 4'h1, 16'h7FFF, 4'b0100, 1'b0);
    send(SUB, 16'h0001, 16'h0002, 4'h2, 16'hFFFF, 4'b1010, 1'b0);
    send(ADD, 16'h7FFF, 16'h0001, 4'h4, 16'h8000, 4'b1100, 1'b0);
    send(SUB, 16'h0005, 16'h0005, 4'h5, 16'h0000, 4'b0001, 1'b0);
    send(AND_, 16'hF0F0, 16'hFF00, 4'h6, 16'hF000, 4'b1000, 1'b0);
    send(OR_,  16'h000F, 16'h00F0, 4'h7, 16'h00FF, 4'b0000, 1'b0);
    send(XOR_, 16'h00FF, 16'h00FF, 4'h8, 16'h0000, 4'b0001, 1'b0);
    send(NOT_, 16'h00FF, 16'h1234, 4'h9, 16'hFF00, 4'b1000, 1'b0);
    send(LTU,  16'h0003, 16'h0005, 4'hA, 16'h0001, 4'b0000, 1'b0);
    send(GTU,  16'h0003, 16'h0005, 4'hB, 16'h0000, 4'b0001, 1'b0);

    // Shifts including amounts at and beyond the width
    send(SHL, 16'h1234, 16'h0010, 4'h1, 16'h0000, 4'b0001, 1'b0);
    send(SRA, 16'h8000, 16'h0014, 4'h2, 16'hFFFF, 4'b1000, 1'b0);
    send(SHR, 16'h8000, 16'h000F, 4'h3, 16'h0001, 4'b0000, 1'b0);
    send(SRA, 16'h8000, 16'h0004, 4'h4, 16'hF800, 4'b1000, 1'b0);
    send(SHL, 16'h0001, 16'h000F, 4'h5, 16'h8000, 4'b1000, 1'b0);

    // Multiply: busy window and operand capture
    repeat (2) @(posedge clk); #1;
    send(MUL, 16'h0100, 16'h0100, 4'h7, 16'h0000, 4'b0011, 1'b0);
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_tag = 4'h0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk("mul_busy_ready_valid", 32'({in_ready, out_valid}), 32'd0);
    end
    @(posedge clk); #1;
    chk("mul_valid_edge17", 32'(out_valid), 32'd1);
    chk("mul_ready_after", 32'(in_ready), 32'd1);
    send(MUL, 16'h0003, 16'h0005, 4'h8, 16'h000F, 4'b0000, 1'b0);
    repeat (20) @(posedge clk); #1;

    // Backpressure: held result, stalled input, simultaneous drain and accept
    out_ready = 1'b0;
    send(ADD, 16'h0001, 16'h0001, 4'h9, 16'h0002, 4'b0000, 1'b0);
    in_valid = 1'b1; in_opcode = XOR_; in_a = 16'h00F0; in_b = 16'h0F0F; in_tag = 4'hA;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold", 32'({out_valid, out_tag, out_result}), 32'({1'b1, 4'h9, 16'h0002}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back('{16'h0FFF, 4'hA, 4'b0000, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("xor_next_cycle", 32'({out_valid, out_result}), 32'({1'b1, 16'h0FFF}));

    // Reset in the middle of a multiply
    send(MUL, 16'h0003, 16'h0005, 4'h5, 16'h000F, 4'b0000, 1'b0);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid",  32'(out_valid),  32'd0);
    chk("midrst_out_result", 32'(out_result), 32'd0);
    chk("midrst_out_tag",    32'(out_tag),    32'd0);
    chk("midrst_out_flags",  32'(out_flags),  32'd0);
    chk("midrst_out_err",    32'(out_err),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("no_stray_valid", 32'(stray), 32'd0);
    @(posedge clk); #1;
    send(ADD, 16'h0002, 16'h0002, 4'h1, 16'h0004, 4'b0000, 1'b0);
    send(ILL, 16'h1234, 16'h5678, 4'h6, 16'h0000, 4'b0000, 1'b1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
